// File: rtl/ppu_pixel_mux.sv
// ppu_pixel_mux: two-stage background/sprite priority mux with 32x6 palette RAM and sprite-0 hit.
// Optional greyscale output masking is enabled by defining PPU_GREYSCALE_EN.
module ppu_pixel_mux (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x_idx,
    input  logic [9:0] scanline,
    input  logic [3:0] bg_pixel,
    input  logic [3:0] spr_pixel,
    input  logic       spr_behind,
    input  logic       spr_zero,
    input  logic       show_bg,
    input  logic       show_spr,
    input  logic       show_bg_left,
    input  logic       show_spr_left,
    input  logic       pal_we,
    input  logic       pal_re,
    input  logic [4:0] pal_addr,
    input  logic [5:0] pal_wdata,
    output logic [5:0] pal_rdata,
    input  logic       spr0_hit_clr,
    output logic       spr0_hit,
`ifdef PPU_GREYSCALE_EN
    input  logic       greyscale,
`endif
    output logic [5:0] color,
    output logic       color_valid,
    output logic [7:0] pixel_x,
    output logic [7:0] pixel_y
);
    // Sprite-palette backdrop entries alias onto the background ones.
    function automatic logic [4:0] mirror(input logic [4:0] a);
        return (a[4] && a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
    endfunction

    logic [5:0] pal_q [32];
    logic [5:0] pal_d [32];
    logic       vis_q, vis_d, valid_q, valid_d, hit_q, hit_d, grey_q, grey_d;
    logic [4:0] idx_q, idx_d;
    logic [7:0] px_q, px_d, py_q, py_d, pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic [5:0] color_q, color_d, rdata_q, rdata_d;
    logic [3:0] bg_m, spr_m;
    logic       bg_op, spr_op;

    always_comb begin
        vis_d = x_idx < 10'd256 && scanline >= 10'd1 && scanline <= 10'd240;
        bg_m = (show_bg && (x_idx >= 10'd8 || show_bg_left)) ? bg_pixel : 4'h0;
        spr_m = (show_spr && (x_idx >= 10'd8 || show_spr_left)) ? spr_pixel : 4'h0;
        bg_op = bg_m[1:0] != 2'b00;
        spr_op = spr_m[1:0] != 2'b00;
        idx_d = !bg_op && !spr_op ? 5'h00 :
                bg_op && (!spr_op || spr_behind) ? mirror({1'b0, bg_m}) : mirror({1'b1, spr_m});
        px_d = x_idx[7:0];
        py_d = scanline[7:0] - 8'd1;
`ifdef PPU_GREYSCALE_EN
        grey_d = greyscale;
        color_d = valid_q ? pal_q[idx_q] & (grey_q ? 6'h30 : 6'h3F) : 6'h00;
`else
        grey_d = 1'b0;
        color_d = vis_q ? pal_q[idx_q] : 6'h00;
`endif
        valid_d = vis_q;
        pixel_x_d = vis_q ? px_q : 8'h00;
        pixel_y_d = vis_q ? py_q : 8'h00;
        rdata_d = pal_re ? pal_q[mirror(pal_addr)] : rdata_q;
        hit_d = spr0_hit_clr ? 1'b0 : hit_q | (vis_d && bg_op && spr_op && spr_zero && x_idx != 10'd255);
        pal_d = pal_q;
        if (pal_we) pal_d[mirror(pal_addr)] = pal_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) pal_q[i] <= 6'h00;
            vis_q <= 1'b0;
            idx_q <= 5'h00;
            px_q <= 8'h00;
            py_q <= 8'h00;
            grey_q <= 1'b0;
            color_q <= 6'h00;
            valid_q <= 1'b0;
            pixel_x_q <= 8'h00;
            pixel_y_q <= 8'h00;
            rdata_q <= 6'h00;
            hit_q <= 1'b0;
        end else begin
            pal_q <= pal_d;
            vis_q <= vis_d;
            idx_q <= idx_d;
            px_q <= px_d;
            py_q <= py_d;
            grey_q <= grey_d;
            color_q <= color_d;
            valid_q <= valid_d;
            pixel_x_q <= pixel_x_d;
            pixel_y_q <= pixel_y_d;
            rdata_q <= rdata_d;
            hit_q <= hit_d;
        end
    end

    assign color = color_q;
    assign color_valid = valid_q;
    assign pixel_x = pixel_x_q;
    assign pixel_y = pixel_y_q;
    assign pal_rdata = rdata_q;
    assign spr0_hit = hit_q;
`ifndef PPU_GREYSCALE_EN
    logic unused_grey;
    assign unused_grey = grey_q;
`endif
endmodule

// File: tb/tb_ppu_pixel_mux.sv
// tb_ppu_pixel_mux: randomized and directed checks of ppu_pixel_mux against a cycle-level reference model.
module tb_ppu_pixel_mux;
    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x_idx, scanline;
    logic [3:0] bg_pixel, spr_pixel;
    logic       spr_behind, spr_zero, show_bg, show_spr, show_bg_left, show_spr_left;
    logic       pal_we, pal_re, spr0_hit_clr, spr0_hit, color_valid;
    logic [4:0] pal_addr;
    logic [5:0] pal_wdata, pal_rdata, color;
    logic [7:0] pixel_x, pixel_y;
`ifdef PPU_GREYSCALE_EN
    logic       greyscale;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] pal_m [32];
    bit         p_vis, p_grey, e_valid, e_hit;
    logic [4:0] p_idx;
    logic [7:0] p_x, p_y, e_px, e_py;
    logic [5:0] e_color, e_rd;

    ppu_pixel_mux dut (
        .clk(clk), .reset(reset), .x_idx(x_idx), .scanline(scanline),
        .bg_pixel(bg_pixel), .spr_pixel(spr_pixel), .spr_behind(spr_behind), .spr_zero(spr_zero),
        .show_bg(show_bg), .show_spr(show_spr), .show_bg_left(show_bg_left), .show_spr_left(show_spr_left),
        .pal_we(pal_we), .pal_re(pal_re), .pal_addr(pal_addr), .pal_wdata(pal_wdata), .pal_rdata(pal_rdata),
        .spr0_hit_clr(spr0_hit_clr), .spr0_hit(spr0_hit),
`ifdef PPU_GREYSCALE_EN
        .greyscale(greyscale),
`endif
        .color(color), .color_valid(color_valid), .pixel_x(pixel_x), .pixel_y(pixel_y)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] mir(input logic [4:0] a);
        return (a >= 5'd16 && a % 4 == 0) ? a - 5'd16 : a;
    endfunction

    // One clock of the reference model, then the edge, then every output compared.
    task automatic tick();
        bit vis, bo, so;
        int bgv, spv, grey;
        if (reset) begin
            for (int i = 0; i < 32; i++) pal_m[i] = 6'h00;
            p_vis = 0; p_idx = 0; p_x = 0; p_y = 0; p_grey = 0;
            e_valid = 0; e_color = 0; e_px = 0; e_py = 0; e_rd = 0; e_hit = 0;
        end else begin
            e_valid = p_vis;
            e_color = p_vis ? (pal_m[p_idx] & (p_grey ? 6'h30 : 6'h3F)) : 6'h00;
            e_px = p_vis ? p_x : 8'h00;
            e_py = p_vis ? p_y : 8'h00;
            if (pal_re) e_rd = pal_m[mir(pal_addr)];
            vis = x_idx < 256 && scanline >= 1 && scanline <= 240;
            bgv = (show_bg && (x_idx >= 8 || show_bg_left)) ? int'(bg_pixel) : 0;
            spv = (show_spr && (x_idx >= 8 || show_spr_left)) ? int'(spr_pixel) : 0;
            bo = bgv % 4 != 0;
            so = spv % 4 != 0;
            if (spr0_hit_clr) e_hit = 0;
            else if (vis && bo && so && spr_zero && x_idx != 255) e_hit = 1;
            p_vis = vis;
            p_x = 8'(int'(x_idx) % 256);
            p_y = 8'((int'(scanline) + 255) % 256);
            if (!bo && !so) p_idx = 0;
            else if (bo && (!so || spr_behind)) p_idx = mir(5'(bgv));
            else p_idx = mir(5'(16 + spv));
            grey = 0;
`ifdef PPU_GREYSCALE_EN
            grey = int'(greyscale);
`endif
            p_grey = grey != 0;
            if (pal_we) pal_m[mir(pal_addr)] = pal_wdata;
        end
        @(posedge clk);
        #1;
        n_cmp += 7;
        if (color !== e_color) begin n_bad++; $display("FAIL color: got %h want %h at %0t", color, e_color, $time); end
        if (color_valid !== e_valid) begin n_bad++; $display("FAIL color_valid: got %b want %b at %0t", color_valid, e_valid, $time); end
        if (pixel_x !== e_px) begin n_bad++; $display("FAIL pixel_x: got %h want %h at %0t", pixel_x, e_px, $time); end
        if (pixel_y !== e_py) begin n_bad++; $display("FAIL pixel_y: got %h want %h at %0t", pixel_y, e_py, $time); end
        if (pal_rdata !== e_rd) begin n_bad++; $display("FAIL pal_rdata: got %h want %h at %0t", pal_rdata, e_rd, $time); end
        if (spr0_hit !== e_hit) begin n_bad++; $display("FAIL spr0_hit: got %b want %b at %0t", spr0_hit, e_hit, $time); end
        if ($isunknown({color, pixel_x, pixel_y, pal_rdata})) begin n_bad++; $display("FAIL xcheck: got unknown outputs at %0t", $time); end
    endtask

    task automatic idle();
        reset = 0; x_idx = 10'd300; scanline = 10'd10;
        bg_pixel = 0; spr_pixel = 0; spr_behind = 0; spr_zero = 0;
        show_bg = 1; show_spr = 1; show_bg_left = 1; show_spr_left = 1;
        pal_we = 0; pal_re = 0; pal_addr = 0; pal_wdata = 0; spr0_hit_clr = 0;
`ifdef PPU_GREYSCALE_EN
        greyscale = 0;
`endif
    endtask

    task automatic pal_write(input logic [4:0] a, input logic [5:0] d);
        pal_we = 1; pal_addr = a; pal_wdata = d;
        tick();
        pal_we = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        repeat (3) tick();
        n_cmp++;
        if ({color, color_valid, pixel_x, pixel_y, pal_rdata, spr0_hit} !== 30'h0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", {color, color_valid, pixel_x, pixel_y, pal_rdata, spr0_hit});
        end
        reset = 0;
    endtask

    task automatic test_basic();
        idle();
        pal_write(5'h05, 6'h2A);
        bg_pixel = 4'h5; x_idx = 10'd100; scanline = 10'd50;
        tick();
        idle();
        tick();
        n_cmp++;
        if ({color, color_valid, pixel_x, pixel_y} !== {6'h2A, 1'b1, 8'd100, 8'd49}) begin
            n_bad++; $display("FAIL basic_pixel: got %h/%b/%0d/%0d want 2a/1/100/49", color, color_valid, pixel_x, pixel_y);
        end
    endtask

    task automatic test_priority();
        idle();
        pal_write(5'h01, 6'h11);
        pal_write(5'h16, 6'h22);
        bg_pixel = 4'h1; spr_pixel = 4'h6; spr_behind = 1; x_idx = 10'd40; scanline = 10'd3;
        tick();
        spr_behind = 0;
        tick();
        n_cmp++;
        if (color !== 6'h11) begin n_bad++; $display("FAIL prio_behind: got %h want 11", color); end
        idle();
        tick();
        n_cmp++;
        if (color !== 6'h22) begin n_bad++; $display("FAIL prio_front: got %h want 22", color); end
    endtask

    task automatic test_mirror();
        idle();
        pal_write(5'h10, 6'h11);
        pal_re = 1; pal_addr = 5'h00;
        tick();
        pal_re = 0;
        n_cmp++;
        if (pal_rdata !== 6'h11) begin n_bad++; $display("FAIL mirror_read: got %h want 11", pal_rdata); end
        tick();
        n_cmp++;
        if (pal_rdata !== 6'h11) begin n_bad++; $display("FAIL rdata_hold: got %h want 11", pal_rdata); end
    endtask

    task automatic test_hit();
        idle();
        spr0_hit_clr = 1;
        tick();
        idle();
        bg_pixel = 4'h1; spr_pixel = 4'h2; spr_zero = 1; scanline = 10'd20;
        x_idx = 10'd5; show_bg_left = 0;
        tick();
        n_cmp++;
        if (spr0_hit !== 1'b0) begin n_bad++; $display("FAIL hit_left_mask: got %b want 0", spr0_hit); end
        show_bg_left = 1; x_idx = 10'd255;
        tick();
        n_cmp++;
        if (spr0_hit !== 1'b0) begin n_bad++; $display("FAIL hit_x255: got %b want 0", spr0_hit); end
        x_idx = 10'd20; spr_behind = 1;
        tick();
        n_cmp++;
        if (spr0_hit !== 1'b1) begin n_bad++; $display("FAIL hit_x20: got %b want 1", spr0_hit); end
        spr0_hit_clr = 1;
        tick();
        n_cmp++;
        if (spr0_hit !== 1'b0) begin n_bad++; $display("FAIL hit_set_clr: got %b want 0", spr0_hit); end
        idle();
    endtask

    task automatic test_invisible();
        idle();
        bg_pixel = 4'h5; x_idx = 10'd300; scanline = 10'd50;
        tick(); tick();
        n_cmp++;
        if ({color_valid, color} !== 7'h00) begin n_bad++; $display("FAIL x300: got %b/%h want 0/00", color_valid, color); end
        x_idx = 10'd100; scanline = 10'd0;
        tick(); tick();
        n_cmp++;
        if ({color_valid, color} !== 7'h00) begin n_bad++; $display("FAIL line0: got %b/%h want 0/00", color_valid, color); end
        scanline = 10'd50;
        tick();
        reset = 1;
        tick();
        n_cmp++;
        if ({color, color_valid, pixel_x, pixel_y, pal_rdata, spr0_hit} !== 30'h0) begin
            n_bad++; $display("FAIL midline_reset: got %h want 0", {color, color_valid, pixel_x, pixel_y, pal_rdata, spr0_hit});
        end
        reset = 0;
        idle();
        tick();
        n_cmp++;
        if (color_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_flush: got %b want 0", color_valid); end
    endtask

`ifdef PPU_GREYSCALE_EN
    task automatic test_greyscale();
        idle();
        pal_write(5'h05, 6'h2A);
        bg_pixel = 4'h5; x_idx = 10'd60; scanline = 10'd60; greyscale = 1;
        tick();
        idle();
        tick();
        n_cmp++;
        if (color !== 6'h20) begin n_bad++; $display("FAIL greyscale: got %h want 20", color); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            reset = $urandom_range(0, 99) == 0;
            x_idx = $urandom_range(0, 3) == 0 ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 340));
            if ($urandom_range(0, 19) == 0) x_idx = 10'd255;
            scanline = 10'($urandom_range(0, 261));
            bg_pixel = 4'($urandom); spr_pixel = 4'($urandom);
            spr_behind = 1'($urandom); spr_zero = $urandom_range(0, 2) == 0;
            show_bg = $urandom_range(0, 7) != 0; show_spr = $urandom_range(0, 7) != 0;
            show_bg_left = 1'($urandom); show_spr_left = 1'($urandom);
            pal_we = $urandom_range(0, 3) == 0; pal_re = $urandom_range(0, 3) == 0;
            pal_addr = 5'($urandom); pal_wdata = 6'($urandom);
            spr0_hit_clr = $urandom_range(0, 15) == 0;
`ifdef PPU_GREYSCALE_EN
            greyscale = $urandom_range(0, 3) == 0;
`endif
            tick();
        end
        idle();
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_mirror();
        test_hit();
        test_invisible();
`ifdef PPU_GREYSCALE_EN
        test_greyscale();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
